// File: rtl/compare_timer_multi.sv
`default_nettype none
// ============================================================================
//  Module      : compare_timer_multi
//  Description : Free-running counter with a programmable wrap period. It is
//                compared every cycle against CHANNELS independently
//                programmable thresholds. Each channel has one of four modes:
//                LE level, GT level, toggle-on-match, or disabled.
//  Ports       : clock        rising-edge clock
//                reset        asynchronous active-high reset
//                enable       counter advance / match qualify
//                clear        synchronous counter and toggle-state clear
//                period       terminal count (counter wraps after reaching it)
//                wr_en        channel configuration write strobe
//                wr_ch        channel to write (values >= CHANNELS ignored)
//                wr_cmp       threshold to load
//                wr_mode      mode to load: 00 LE, 01 GT, 10 TOG, 11 DIS
//                count        registered counter value
//                wrap         one-cycle pulse on period wrap
//                match_pulse  per-channel one-cycle equality strobe
//                level        per-channel registered compare/toggle output
//  Revision    : 1.0  initial release
// ============================================================================
module compare_timer_multi #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic [WIDTH-1:0]    period,
    input  logic                wr_en,
    input  logic [CH_BITS-1:0]  wr_ch,
    input  logic [WIDTH-1:0]    wr_cmp,
    input  logic [1:0]          wr_mode,
    output logic [WIDTH-1:0]    count,
    output logic                wrap,
    output logic [CHANNELS-1:0] match_pulse,
    output logic [CHANNELS-1:0] level
);

    localparam logic [1:0] MODE_LE  = 2'b00;
    localparam logic [1:0] MODE_GT  = 2'b01;
    localparam logic [1:0] MODE_TOG = 2'b10;
    localparam logic [1:0] MODE_DIS = 2'b11;

    // ------------------------------------------------------------------
    // Counter. A live compare against period; if period drops below the
    // current count, the counter simply runs on and overflows to zero
    // without a wrap pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (enable && (count == period)) begin
            count <= '0;
            wrap  <= 1'b1;
        end else if (enable) begin
            count <= count + 1'b1;
            wrap  <= 1'b0;
        end else begin
            wrap  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Channels. Evaluation uses the pre-update count, so outputs trail
    // count by one cycle. Selecting a channel index only matches indices
    // below CHANNELS, so out-of-range writes fall through untouched.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [WIDTH-1:0] cmp;
            logic [1:0]       mode;
            logic             lvl;
            logic             pls;
            logic             sel;
            logic             match;

            assign sel   = wr_en && (wr_ch == CH_BITS'(i));
            assign match = enable && !clear && (count == cmp) && (mode != MODE_DIS);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cmp  <= '0;
                    mode <= MODE_DIS;
                    lvl  <= 1'b0;
                    pls  <= 1'b0;
                end else if (sel) begin
                    // A write resets the channel outputs; any coincident
                    // match against the old settings is dropped.
                    cmp  <= wr_cmp;
                    mode <= wr_mode;
                    lvl  <= 1'b0;
                    pls  <= 1'b0;
                end else begin
                    pls <= match;
                    case (mode)
                        MODE_LE:  lvl <= (count <= cmp);
                        MODE_GT:  lvl <= (count > cmp);
                        MODE_TOG: lvl <= clear ? 1'b0 : (lvl ^ match);
                        default:  lvl <= 1'b0;
                    endcase
                end
            end

            assign level[i]       = lvl;
            assign match_pulse[i] = pls;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_compare_timer_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compare_timer_multi
//  Description : Self-checking bench for compare_timer_multi. A behavioural
//                model predicts every output each cycle. Directed phases pin
//                key values with literals. A randomized phase follows.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_compare_timer_multi;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int CB = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic [W-1:0]  period = '0;
    logic          wr_en = 1'b0;
    logic [CB-1:0] wr_ch = '0;
    logic [W-1:0]  wr_cmp = '0;
    logic [1:0]    wr_mode = 2'b00;
    logic [W-1:0]  count;
    logic          wrap;
    logic [CH-1:0] match_pulse;
    logic [CH-1:0] level;

    compare_timer_multi #(.WIDTH(W), .CHANNELS(CH), .CH_BITS(CB)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .period(period), .wr_en(wr_en), .wr_ch(wr_ch), .wr_cmp(wr_cmp),
        .wr_mode(wr_mode), .count(count), .wrap(wrap),
        .match_pulse(match_pulse), .level(level)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: plain integers, one update per rising edge.
    // ------------------------------------------------------------------
    int unsigned m_count = 0;
    bit          m_wrap  = 0;
    int unsigned m_cmp [CH];
    int          m_mode[CH];   // 0 LE, 1 GT, 2 TOG, 3 DIS
    bit          m_lvl [CH];
    bit          m_pls [CH];

    initial begin
        for (int k = 0; k < CH; k++) begin
            m_cmp[k] = 0; m_mode[k] = 3; m_lvl[k] = 0; m_pls[k] = 0;
        end
    end

    always @(posedge clock) begin
        int unsigned c;
        bit hit;
        logic [CH-1:0] exp_l, exp_p;
        if (reset) begin
            m_count = 0; m_wrap = 0;
            for (int k = 0; k < CH; k++) begin
                m_cmp[k] = 0; m_mode[k] = 3; m_lvl[k] = 0; m_pls[k] = 0;
            end
        end else begin
            c = m_count;
            for (int k = 0; k < CH; k++) begin
                hit = enable && !clear && (c == m_cmp[k]) && (m_mode[k] != 3);
                if (wr_en && int'(wr_ch) == k) begin
                    m_cmp[k]  = wr_cmp;
                    m_mode[k] = int'(wr_mode);
                    m_lvl[k]  = 0;
                    m_pls[k]  = 0;
                end else begin
                    m_pls[k] = hit;
                    if (m_mode[k] == 0)      m_lvl[k] = (c <= m_cmp[k]);
                    else if (m_mode[k] == 1) m_lvl[k] = (c > m_cmp[k]);
                    else if (m_mode[k] == 2) m_lvl[k] = clear ? 0 : (m_lvl[k] ^ hit);
                    else                     m_lvl[k] = 0;
                end
            end
            if (clear)                         begin m_count = 0;             m_wrap = 0; end
            else if (enable && c == period)    begin m_count = 0;             m_wrap = 1; end
            else if (enable)                   begin m_count = (c + 1) % 256; m_wrap = 0; end
            else                               begin                          m_wrap = 0; end
        end
        for (int k = 0; k < CH; k++) begin
            exp_l[k] = m_lvl[k];
            exp_p[k] = m_pls[k];
        end
        #1;
        chk("model_count", 32'(count), m_count);
        chk("model_wrap", 32'(wrap), 32'(m_wrap));
        chk("model_match_pulse", 32'(match_pulse), 32'(exp_p));
        chk("model_level", 32'(level), 32'(exp_l));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic write(input int ch, input int cmp, input int mode);
        wr_en = 1'b1; wr_ch = CB'(ch); wr_cmp = W'(cmp); wr_mode = 2'(mode);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_count(input int val, input int limit);
        for (int k = 0; k < limit && int'(count) != val; k++) tick();
        chk("wait_count", 32'(count), 32'(val));
    endtask

    initial begin
        // Reset is applied without a clock edge and must act immediately.
        #1 reset = 1'b1;
        #1;
        chk("reset_count", 32'(count), 0);
        chk("reset_level", 32'(level), 0);
        chk("reset_pulse", 32'(match_pulse), 0);
        tick(2);
        reset = 1'b0;
        tick();

        // Configure: ch0 LE 3, ch1 TOG 0, ch2 GT 9, ch3 LE 9.
        write(0, 3, 0);
        write(1, 0, 2);
        write(2, 9, 1);
        write(3, 9, 0);

        period = 8'd7; enable = 1'b1; clear = 1'b1;
        tick();
        chk("clr_count", 32'(count), 0);
        chk("clr_tog", 32'(level[1]), 0);
        clear = 1'b0;
        tick();
        chk("e1_count", 32'(count), 1);
        chk("e1_pulse", 32'(match_pulse), 32'h2);
        chk("e1_level", 32'(level), 32'hB);
        tick(4);
        chk("e5_count", 32'(count), 5);
        chk("e5_le_low", 32'(level[0]), 0);
        tick(3);
        chk("e8_wrap", 32'(wrap), 1);
        chk("e8_count", 32'(count), 0);
        chk("e8_gt_never", 32'(level[2]), 0);
        chk("e8_le_always", 32'(level[3]), 1);

        // Divider with period 4: the model tracks the 10-cycle square wave.
        period = 8'd4;
        tick(25);

        // A write coincident with a match drops that match.
        write(0, 2, 0);
        wait_count(2, 20);
        wr_en = 1'b1; wr_ch = 3'd0; wr_cmp = 8'd2; wr_mode = 2'b00;
        tick();
        wr_en = 1'b0;
        chk("wr_coinc_pulse", 32'(match_pulse[0]), 0);
        chk("wr_coinc_level", 32'(level[0]), 0);
        tick(6);

        // Hold with enable low, then clear.
        wait_count(3, 20);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_count", 32'(count), 3);
            chk("hold_wrap", 32'(wrap), 0);
        end
        enable = 1'b1; clear = 1'b1;
        tick();
        chk("clear_count", 32'(count), 0);
        chk("clear_pulse", 32'(match_pulse), 0);
        chk("clear_tog", 32'(level[1]), 0);
        clear = 1'b0;

        // Period dropped below count: natural overflow, no wrap pulse.
        period = 8'd200;
        wait_count(150, 200);
        period = 8'd10;
        wait_count(255, 200);
        tick();
        chk("ovf_count", 32'(count), 0);
        chk("ovf_wrap", 32'(wrap), 0);
        tick(3);

        // Randomized traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            enable  = ($urandom_range(0, 9) < 8);
            clear   = ($urandom_range(0, 31) == 0);
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_ch   = CB'($urandom_range(0, 7));
            wr_cmp  = W'($urandom_range(0, 12));
            wr_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) period = W'($urandom_range(0, 10));
            tick();
        end
        wr_en = 1'b0; clear = 1'b0; enable = 1'b1;

        // Asynchronous reset mid-count.
        period = 8'd20;
        wait_count(6, 40);
        reset = 1'b1;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_level", 32'(level), 0);
        chk("async_pulse", 32'(match_pulse), 0);
        chk("async_wrap", 32'(wrap), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_count", 32'(count), 1);

        // Out-of-range channel write leaves every channel disabled.
        wr_en = 1'b1; wr_ch = 3'd5; wr_cmp = 8'd2; wr_mode = 2'b10;
        tick();
        wr_en = 1'b0;
        tick(4);
        chk("oob_level", 32'(level), 0);
        chk("oob_pulse", 32'(match_pulse), 0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/compare_timer_multi.md
Name: compare_timer_multi

Overview:
- Parametrised multi-channel compare timer: one free-running counter with programmable wrap period, compared each cycle against CHANNELS independently programmable thresholds.
- Per-channel mode: less-or-equal level, greater-than level, toggle-on-match (clock-divider output) or disabled.
- Sits in the clock-divider datapath; generates divided clocks, duty-cycle levels and match strobes for downstream logic.

Parameters:
- WIDTH, 32, counter/threshold/period width in bits (>=2).
- CHANNELS, 4, number of compare channels (>=1).
- CH_BITS, 2, width of channel select; must satisfy 2**CH_BITS >= CHANNELS.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  counter advance / match qualify.
- clear  input  1  synchronous counter and toggle-state clear.
- period  input  WIDTH  terminal count; counter wraps after reaching it.
- wr_en  input  1  channel configuration write strobe.
- wr_ch  input  CH_BITS  channel to write; values >= CHANNELS are ignored.
- wr_cmp  input  WIDTH  threshold to load.
- wr_mode  input  2  mode to load: 00 LE, 01 GT, 10 TOG, 11 DIS.
- count  output  WIDTH  current counter value (registered).
- wrap  output  1  one-cycle pulse on counter wrap.
- match_pulse  output  CHANNELS  one-cycle pulse per channel on equality match.
- level  output  CHANNELS  per-channel registered compare/toggle output.

Behaviour:
- Reset (async, immediate): count=0, wrap=0, match_pulse=0, level=0, all cmp_i=0, all mode_i=DIS.
- Counter, per edge, priority order:
  - clear: count<=0, wrap<=0.
  - else enable and count==period: count<=0, wrap<=1.
  - else enable: count<=count+1, wrap<=0.
  - else: hold, wrap<=0.
- period=0 with enable high: count stays 0; wrap pulses every cycle.
- period may change at any time and is compared live.
- If count>period after a period decrease, the counter runs up to 2**WIDTH-1 and wraps to 0 by natural overflow; no wrap pulse is issued on that overflow.
- Channel evaluation uses the pre-update registered count c and the stored cmp_i and mode_i. Outputs are therefore one cycle behind count.
- match_i = enable & ~clear & (c==cmp_i) & (mode_i!=DIS).
- match_pulse_i <= match_i.
- level_i next value by mode:
  - LE: (c<=cmp_i).
  - GT: (c>cmp_i).
  - TOG: 0 if clear, else level_i ^ match_i.
  - DIS: 0.
- Comparisons are unsigned, full WIDTH. LE and GT track c even when enable is low.
- Configuration write (wr_en & wr_ch<CHANNELS):
  - cmp/mode load on the edge.
  - That channel's level and match_pulse are forced to 0 on the same edge.
  - The new values first affect evaluation on the following edge.
  - A match coincident with a write to the same channel is discarded.
- Other channels are unaffected by a write.
- Writes with wr_ch>=CHANNELS are ignored entirely.
- cmp_i>period: no match ever occurs; LE level stays 1 and TOG level holds.
- TOG with cmp_i<=period yields a square wave with period 2*(period+1) enabled cycles.
- Reset asserted mid-operation returns everything to reset values. The first enabled cycle after release counts 0->1.

Test Plan:
- Reset, then write ch0 cmp=3 mode=LE, period=7, enable=1 -> level[0] high while count (one cycle earlier) is 0..3 and low for 4..7; wrap pulses when count returns to 0 every 8 cycles.
- ch1 TOG cmp=0, period=4 -> level[1] toggles once per 5 cycles (10-cycle square wave); match_pulse[1] pulses 1 cycle after each count==0.
- ch2 GT cmp=9, period=5 -> level[2] never high, match_pulse[2] never pulses; ch3 LE cmp=9 -> level[3] constantly 1.
- Write ch0 cmp=2 on the same edge that count==2 with old cmp=2 -> match_pulse[0]=0 and level[0]=0 next cycle; the next match occurs on the following period.
- enable low for 5 cycles at count=3 -> count holds 3, no match_pulse or wrap; pulse clear -> count=0, TOG levels=0, no pulses that cycle.
- Assert reset asynchronously mid-count (count=6) -> all outputs 0 without a clock edge, modes return to DIS; wr_ch=5 with CHANNELS=4 -> no state change.
